ecc_mont_exp: RTL and testbench

//   Modular-exponentiation sequencer sitting directly upstream of the ECC Montgomery multiplier.

---
 rtl/ecc_mont_exp_pkg.sv | 29 ++
 rtl/ecc_mont_exp.sv | 200 ++++++++++++++++++++
 tb/tb_ecc_mont_exp.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_mont_exp_pkg.sv
// Shared types for the ecc_mont_exp modular-exponentiation sequencer.
package ecc_mont_exp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TOMONT_ISSUE,
        ST_TOMONT_WAIT,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_SQR_ISSUE,
        ST_SQR_WAIT,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_FROMMONT_ISSUE,
        ST_FROMMONT_WAIT
    } state_e;

    typedef enum logic [2:0] {
        OPS_NONE,
        OPS_BASE_R2,
        OPS_R2_ONE,
        OPS_ACC_ACC,
        OPS_ACC_BASEM,
        OPS_ACC_ONE
    } op_sel_e;

    localparam int unsigned MM_ONE = 1;

endpackage

// File: rtl/ecc_mont_exp.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Define ECC_MONT_EXP_CT_EN for constant-time operation (MUL issued for every exponent bit).
module ecc_mont_exp #(
    parameter int unsigned REG_SIZE = 384,
    parameter int unsigned RADIX    = 32,
    parameter int unsigned EXP_SIZE = 384
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                start_i,
    input  logic [REG_SIZE-1:0] base_i,
    input  logic [EXP_SIZE-1:0] exp_i,
    input  logic [REG_SIZE-1:0] n_i,
    input  logic [RADIX-1:0]    n_prime_i,
    input  logic [REG_SIZE-1:0] r2_i,
    output logic [REG_SIZE-1:0] res_o,
    output logic                ready_o,
    output logic                mm_start_o,
    output logic [REG_SIZE-1:0] mm_opa_o,
    output logic [REG_SIZE-1:0] mm_opb_o,
    output logic [REG_SIZE-1:0] mm_n_o,
    output logic [RADIX-1:0]    mm_n_prime_o,
    input  logic [REG_SIZE-1:0] mm_p_i,
    input  logic                mm_ready_i
);
    import ecc_mont_exp_pkg::*;

    localparam int unsigned         CNT_W   = (EXP_SIZE > 1) ? $clog2(EXP_SIZE) : 1;
    localparam logic [CNT_W-1:0]    BIT_TOP = CNT_W'(EXP_SIZE - 1);
    localparam logic [REG_SIZE-1:0] ONE     = REG_SIZE'(MM_ONE);
`ifdef ECC_MONT_EXP_CT_EN
    localparam bit CT_EN = 1'b1;
`else
    localparam bit CT_EN = 1'b0;
`endif

    state_e              r_state, w_state_nxt;
    op_sel_e             w_op_sel;
    logic [REG_SIZE-1:0] r_base, r_r2, r_base_m, r_acc, r_res, r_n, r_opa, r_opb;
    logic [RADIX-1:0]    r_np;
    logic [EXP_SIZE-1:0] r_exp;
    logic [CNT_W-1:0]    r_bit;
    logic                w_accept, w_bit_dec, w_cap_base_m, w_cap_acc, w_cap_res;
    logic                w_exp_bit, w_last_bit;
    logic [REG_SIZE-1:0] w_base_d, w_r2_d, w_base_m_d, w_acc_d, w_opa_d, w_opb_d;
`ifdef ECC_MONT_EXP_CT_EN
    logic                w_cap_dummy;
    logic [REG_SIZE-1:0] r_dummy;
`endif

    assign w_exp_bit  = r_exp[r_bit];
    assign w_last_bit = (r_bit == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_state <= ST_IDLE;
        else if (zeroize) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_bit_dec    = 1'b0;
        w_cap_base_m = 1'b0;
        w_cap_acc    = 1'b0;
        w_cap_res    = 1'b0;
`ifdef ECC_MONT_EXP_CT_EN
        w_cap_dummy  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (start_i) begin
                w_accept    = 1'b1;
                w_state_nxt = ST_TOMONT_ISSUE;
            end
            ST_TOMONT_ISSUE:   w_state_nxt = ST_TOMONT_WAIT;
            ST_INIT_ISSUE:     w_state_nxt = ST_INIT_WAIT;
            ST_SQR_ISSUE:      w_state_nxt = ST_SQR_WAIT;
            ST_MUL_ISSUE:      w_state_nxt = ST_MUL_WAIT;
            ST_FROMMONT_ISSUE: w_state_nxt = ST_FROMMONT_WAIT;
            ST_TOMONT_WAIT: if (mm_ready_i) begin
                w_cap_base_m = 1'b1;
                w_state_nxt  = ST_INIT_ISSUE;
            end
            ST_INIT_WAIT: if (mm_ready_i) begin
                w_cap_acc   = 1'b1;
                w_state_nxt = ST_SQR_ISSUE;
            end
            ST_SQR_WAIT: if (mm_ready_i) begin
                w_cap_acc = 1'b1;
                if (CT_EN || w_exp_bit) begin
                    w_state_nxt = ST_MUL_ISSUE;
                end else if (w_last_bit) begin
                    w_state_nxt = ST_FROMMONT_ISSUE;
                end else begin
                    w_bit_dec   = 1'b1;
                    w_state_nxt = ST_SQR_ISSUE;
                end
            end
            ST_MUL_WAIT: if (mm_ready_i) begin
                // Zero-bit products (constant-time build only) are parked away from acc.
                w_cap_acc = w_exp_bit;
`ifdef ECC_MONT_EXP_CT_EN
                w_cap_dummy = !w_exp_bit;
`endif
                if (w_last_bit) begin
                    w_state_nxt = ST_FROMMONT_ISSUE;
                end else begin
                    w_bit_dec   = 1'b1;
                    w_state_nxt = ST_SQR_ISSUE;
                end
            end
            ST_FROMMONT_WAIT: if (mm_ready_i) begin
                w_cap_res   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands are registered on entry to ISSUE, so they use the values the data regs are about to take.
    assign w_base_d   = w_accept ? base_i : r_base;
    assign w_r2_d     = w_accept ? r2_i : r_r2;
    assign w_base_m_d = w_cap_base_m ? mm_p_i : r_base_m;
    assign w_acc_d    = w_cap_acc ? mm_p_i : r_acc;

    always_comb begin
        w_op_sel = OPS_NONE;
        case (w_state_nxt)
            ST_TOMONT_ISSUE:   w_op_sel = OPS_BASE_R2;
            ST_INIT_ISSUE:     w_op_sel = OPS_R2_ONE;
            ST_SQR_ISSUE:      w_op_sel = OPS_ACC_ACC;
            ST_MUL_ISSUE:      w_op_sel = OPS_ACC_BASEM;
            ST_FROMMONT_ISSUE: w_op_sel = OPS_ACC_ONE;
            default:           w_op_sel = OPS_NONE;
        endcase
        w_opa_d = r_opa;
        w_opb_d = r_opb;
        case (w_op_sel)
            OPS_BASE_R2:   begin w_opa_d = w_base_d; w_opb_d = w_r2_d;     end
            OPS_R2_ONE:    begin w_opa_d = w_r2_d;   w_opb_d = ONE;        end
            OPS_ACC_ACC:   begin w_opa_d = w_acc_d;  w_opb_d = w_acc_d;    end
            OPS_ACC_BASEM: begin w_opa_d = w_acc_d;  w_opb_d = w_base_m_d; end
            OPS_ACC_ONE:   begin w_opa_d = w_acc_d;  w_opb_d = ONE;        end
            default:       begin w_opa_d = r_opa;    w_opb_d = r_opb;      end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || zeroize) begin
            r_base   <= '0;
            r_r2     <= '0;
            r_base_m <= '0;
            r_acc    <= '0;
            r_res    <= '0;
            r_n      <= '0;
            r_np     <= '0;
            r_exp    <= '0;
            r_bit    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
        end else begin
            if (w_accept) begin
                r_base <= base_i;
                r_r2   <= r2_i;
                r_n    <= n_i;
                r_np   <= n_prime_i;
                r_exp  <= exp_i;
                r_bit  <= BIT_TOP;
            end else if (w_bit_dec) begin
                r_bit <= r_bit - CNT_W'(1);
            end
            if (w_cap_base_m) r_base_m <= mm_p_i;
            if (w_cap_acc)    r_acc    <= mm_p_i;
            if (w_cap_res)    r_res    <= mm_p_i;
            if (w_op_sel != OPS_NONE) begin
                r_opa <= w_opa_d;
                r_opb <= w_opb_d;
            end
        end
    end

`ifdef ECC_MONT_EXP_CT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || zeroize) r_dummy <= '0;
        else if (w_cap_dummy)    r_dummy <= mm_p_i;
    end
`endif

    assign ready_o      = (r_state == ST_IDLE);
    assign mm_start_o   = (r_state == ST_TOMONT_ISSUE) || (r_state == ST_INIT_ISSUE) ||
                          (r_state == ST_SQR_ISSUE) || (r_state == ST_MUL_ISSUE) ||
                          (r_state == ST_FROMMONT_ISSUE);
    assign res_o        = r_res;
    assign mm_opa_o     = r_opa;
    assign mm_opb_o     = r_opb;
    assign mm_n_o       = r_n;
    assign mm_n_prime_o = r_np;

endmodule

// File: tb/tb_ecc_mont_exp.sv
// Self-checking bench for ecc_mont_exp with a behavioural word-serial Montgomery multiplier.
// Expected results come from a right-to-left modexp reference; honours ECC_MONT_EXP_CT_EN.
module tb_ecc_mont_exp;
    localparam int unsigned REG_SIZE  = 384;
    localparam int unsigned RADIX     = 32;
    localparam int unsigned EXP_SIZE  = 384;
    localparam int unsigned RUN_LIMIT = 8000;
    localparam int unsigned BW        = 2*REG_SIZE + RADIX + 2;

    typedef logic [REG_SIZE-1:0]   op_t;
    typedef logic [EXP_SIZE-1:0]   exp_t;
    typedef logic [2*REG_SIZE:0]   wide_t;
    typedef logic [BW-1:0]         big_t;

    logic         clk = 1'b0;
    logic         reset_n, zeroize, start_i;
    op_t          base_i, n_i, r2_i, res_o, mm_opa_o, mm_opb_o, mm_n_o, mm_p_i;
    exp_t         exp_i;
    logic [RADIX-1:0] n_prime_i, mm_n_prime_o;
    logic         ready_o, mm_start_o, mm_ready_i;

    int unsigned  errors = 0;
    int unsigned  checks = 0;
    int unsigned  mm_starts = 0;
    int unsigned  fixed_lat = 0;
    int unsigned  run_s0 = 0;
    op_t          p384;

    logic         mm_ready_m, mm_busy, inject;
    op_t          mm_p_m, mm_pend, inj_p;
    int unsigned  mm_lat;

    ecc_mont_exp #(.REG_SIZE(REG_SIZE), .RADIX(RADIX), .EXP_SIZE(EXP_SIZE)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
        .base_i(base_i), .exp_i(exp_i), .n_i(n_i), .n_prime_i(n_prime_i), .r2_i(r2_i),
        .res_o(res_o), .ready_o(ready_o), .mm_start_o(mm_start_o),
        .mm_opa_o(mm_opa_o), .mm_opb_o(mm_opb_o), .mm_n_o(mm_n_o), .mm_n_prime_o(mm_n_prime_o),
        .mm_p_i(mm_p_i), .mm_ready_i(mm_ready_i)
    );

    always #5 clk = ~clk;

    function automatic op_t mont_mul(input op_t a, input op_t b, input op_t n, input logic [RADIX-1:0] np);
        big_t t;
        logic [RADIX-1:0] m;
        t = big_t'(a) * big_t'(b);
        for (int unsigned i = 0; i < REG_SIZE/RADIX; i++) begin
            m = t[RADIX-1:0] * np;
            t = (t + big_t'(m) * big_t'(n)) >> RADIX;
        end
        if (t >= big_t'(n)) t = t - big_t'(n);
        return t[REG_SIZE-1:0];
    endfunction

    function automatic logic [RADIX-1:0] calc_np(input op_t n);
        logic [RADIX-1:0] inv, n0;
        n0  = n[RADIX-1:0];
        inv = 1;
        for (int i = 0; i < 6; i++) inv = inv * (RADIX'(2) - n0 * inv);
        return ~inv + RADIX'(1);
    endfunction

    function automatic op_t ref_modexp(input op_t b, input exp_t e, input op_t n);
        wide_t r, x, nn;
        nn = wide_t'(n);
        r  = wide_t'(1);
        x  = wide_t'(b) % nn;
        for (int i = 0; i < EXP_SIZE; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return op_t'(r);
    endfunction

    function automatic int unsigned exp_mults(input exp_t e);
`ifdef ECC_MONT_EXP_CT_EN
        return 3 + 2*EXP_SIZE + 0*$countones(e);
`else
        return 3 + EXP_SIZE + $countones(e);
`endif
    endfunction

    function automatic op_t rand_op();
        op_t v;
        v = '0;
        for (int unsigned i = 0; i < REG_SIZE/32; i++) v = {v[REG_SIZE-33:0], 32'($urandom())};
        return v;
    endfunction

    // Behavioural multiplier: accepts mm_start_o, answers after 1..3 cycles (or fixed_lat).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_ready_m <= 1'b0;
            mm_busy    <= 1'b0;
            mm_lat     <= 0;
            mm_p_m     <= '0;
            mm_pend    <= '0;
        end else begin
            mm_ready_m <= 1'b0;
            if (mm_start_o) begin
                mm_pend <= mont_mul(mm_opa_o, mm_opb_o, mm_n_o, mm_n_prime_o);
                mm_busy <= 1'b1;
                mm_lat  <= (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
            end else if (mm_busy) begin
                if (mm_lat <= 1) begin
                    mm_ready_m <= 1'b1;
                    mm_p_m     <= mm_pend;
                    mm_busy    <= 1'b0;
                end else begin
                    mm_lat <= mm_lat - 1;
                end
            end
        end
    end

    always @(posedge clk) if (mm_start_o) mm_starts <= mm_starts + 1;

    assign mm_ready_i = mm_ready_m | inject;
    assign mm_p_i     = inject ? inj_p : mm_p_m;

    task automatic start_run(input op_t b, input exp_t e, input op_t n);
        wide_t r2;
        r2 = (wide_t'(1) << (2*REG_SIZE)) % wide_t'(n);
        @(negedge clk);
        base_i    = b;
        exp_i     = e;
        n_i       = n;
        n_prime_i = calc_np(n);
        r2_i      = op_t'(r2);
        start_i   = 1'b1;
        run_s0    = mm_starts;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_done(output op_t res, output int unsigned starts, output int unsigned cycles, output bit done);
        cycles = 1;
        while (!ready_o && cycles < RUN_LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        done   = ready_o;
        res    = res_o;
        starts = mm_starts - run_s0;
    endtask

    task automatic test_reset();
        checks++; if (ready_o !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (mm_start_o !== 1'b0) begin errors++; $display("FAIL reset_mm_start: got %b expected 0", mm_start_o); end
        checks++; if (res_o !== '0)        begin errors++; $display("FAIL reset_res: got %h expected 0", res_o); end
        checks++; if (mm_opa_o !== '0 || mm_opb_o !== '0) begin errors++; $display("FAIL reset_ops: got %h / %h expected 0", mm_opa_o, mm_opb_o); end
        checks++; if (mm_n_o !== '0 || mm_n_prime_o !== '0) begin errors++; $display("FAIL reset_n: got %h / %h expected 0", mm_n_o, mm_n_prime_o); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_basic();
        op_t res; int unsigned st, cy; bit ok; exp_t e;
        e = exp_t'(10);
        start_run(op_t'(2), e, p384);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL busy_after_start: got %b expected 0", ready_o); end
        wait_done(res, st, cy, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy after %0d cycles expected done", cy); end
        checks++; if (res !== op_t'(1024)) begin errors++; $display("FAIL basic_res: got %h expected %h", res, op_t'(1024)); end
        checks++; if (st !== exp_mults(e)) begin errors++; $display("FAIL basic_mm_count: got %0d expected %0d", st, exp_mults(e)); end
        checks++; if (mm_n_o !== p384 || mm_n_prime_o !== calc_np(p384)) begin errors++; $display("FAIL basic_latched_n: got %h / %h expected %h / %h", mm_n_o, mm_n_prime_o, p384, calc_np(p384)); end
    endtask

    task automatic test_exp_zero();
        op_t res; int unsigned st, cy; bit ok;
        start_run(op_t'(5), '0, p384);
        wait_done(res, st, cy, ok);
        checks++; if (!ok) begin errors++; $display("FAIL exp0_timeout: got busy after %0d cycles expected done", cy); end
        checks++; if (res !== op_t'(1)) begin errors++; $display("FAIL exp0_res: got %h expected 1", res); end
        checks++; if (st !== exp_mults('0)) begin errors++; $display("FAIL exp0_mm_count: got %0d expected %0d", st, exp_mults('0)); end
    endtask

    task automatic test_edge_exponents();
        op_t res, pm1; int unsigned st, cy1, cyf; bit ok; exp_t e; wide_t prod;
        fixed_lat = 2;
        pm1 = p384 - op_t'(1);
        start_run(pm1, exp_t'(1), p384);
        wait_done(res, st, cy1, ok);
        checks++; if (!ok || res !== pm1) begin errors++; $display("FAIL exp1_res: got %h expected %h", res, pm1); end
        checks++; if (st !== exp_mults(exp_t'(1))) begin errors++; $display("FAIL exp1_mm_count: got %0d expected %0d", st, exp_mults(exp_t'(1))); end
        e = exp_t'(p384 - op_t'(2));
        start_run(op_t'(3), e, p384);
        wait_done(res, st, cyf, ok);
        prod = (wide_t'(3) * wide_t'(res)) % wide_t'(p384);
        checks++; if (!ok || prod !== wide_t'(1)) begin errors++; $display("FAIL fermat_inverse: got 3*res mod p = %h expected 1", prod); end
        checks++; if (res !== ref_modexp(op_t'(3), e, p384)) begin errors++; $display("FAIL fermat_res: got %h expected %h", res, ref_modexp(op_t'(3), e, p384)); end
        checks++; if (st !== exp_mults(e)) begin errors++; $display("FAIL fermat_mm_count: got %0d expected %0d", st, exp_mults(e)); end
`ifdef ECC_MONT_EXP_CT_EN
        checks++; if (cyf !== cy1) begin errors++; $display("FAIL ct_timing: got %0d cycles expected %0d", cyf, cy1); end
`endif
        fixed_lat = 0;
    endtask

    task automatic test_random();
        op_t res, n, b, exp_res; int unsigned st, cy; bit ok; exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                n = rand_op();
                n[REG_SIZE-1] = 1'b1;
                n[0] = 1'b1;
            end else begin
                n = p384;
            end
            b = op_t'(wide_t'(rand_op()) % wide_t'(n));
            e = exp_t'(rand_op());
            exp_res = ref_modexp(b, e, n);
            start_run(b, e, n);
            wait_done(res, st, cy, ok);
            checks++; if (!ok || res !== exp_res) begin errors++; $display("FAIL random_res[%0d]: got %h expected %h", k, res, exp_res); end
            checks++; if (st !== exp_mults(e)) begin errors++; $display("FAIL random_mm_count[%0d]: got %0d expected %0d", k, st, exp_mults(e)); end
        end
    endtask

    task automatic test_busy_start();
        op_t res, b, exp_res; int unsigned st, cy; bit ok; exp_t e;
        b = op_t'(wide_t'(rand_op()) % wide_t'(p384));
        e = exp_t'(rand_op());
        exp_res = ref_modexp(b, e, p384);
        start_run(b, e, p384);
        repeat (50) @(negedge clk);
        base_i    = b ^ op_t'(32'h5a5a);
        exp_i     = ~e;
        n_i       = rand_op();
        n_prime_i = 32'($urandom());
        r2_i      = rand_op();
        start_i   = 1'b1;
        repeat (3) @(negedge clk);
        start_i   = 1'b0;
        wait_done(res, st, cy, ok);
        checks++; if (!ok || res !== exp_res) begin errors++; $display("FAIL busy_start_res: got %h expected %h", res, exp_res); end
        checks++; if (st !== exp_mults(e)) begin errors++; $display("FAIL busy_start_mm_count: got %0d expected %0d", st, exp_mults(e)); end
    endtask

    task automatic test_zeroize();
        op_t res, b, exp_res, res_before; int unsigned st, cy, s0; bit ok; exp_t e;
        res_before = res_o;
        start_run(op_t'(7), exp_t'(rand_op()), p384);
        repeat (498) @(negedge clk);
        checks++; if (ready_o !== 1'b0 || res_o !== res_before) begin errors++; $display("FAIL zeroize_pre_busy: got ready=%b res=%h expected 0 / %h", ready_o, res_o, res_before); end
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL zeroize_ready: got %b expected 1", ready_o); end
        checks++; if (res_o !== '0) begin errors++; $display("FAIL zeroize_res: got %h expected 0", res_o); end
        checks++; if (mm_opa_o !== '0 || mm_n_o !== '0 || mm_n_prime_o !== '0) begin errors++; $display("FAIL zeroize_regs: got %h / %h / %h expected 0", mm_opa_o, mm_n_o, mm_n_prime_o); end
        s0 = mm_starts;
        repeat (20) @(negedge clk);
        checks++; if (mm_starts !== s0) begin errors++; $display("FAIL zeroize_no_start: got %0d pulses expected 0", mm_starts - s0); end
        checks++; if (res_o !== '0 || ready_o !== 1'b1) begin errors++; $display("FAIL zeroize_late_ready: got res=%h ready=%b expected 0 / 1", res_o, ready_o); end
        inj_p  = rand_op();
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        checks++; if (res_o !== '0 || ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready_ignored: got res=%h ready=%b expected 0 / 1", res_o, ready_o); end
        b = op_t'(wide_t'(rand_op()) % wide_t'(p384));
        e = exp_t'(rand_op());
        exp_res = ref_modexp(b, e, p384);
        start_run(b, e, p384);
        wait_done(res, st, cy, ok);
        checks++; if (!ok || res !== exp_res) begin errors++; $display("FAIL post_zeroize_res: got %h expected %h", res, exp_res); end
    endtask

    task automatic test_async_reset();
        op_t res, b, exp_res; int unsigned st, cy; bit ok; exp_t e;
        start_run(op_t'(11), exp_t'(rand_op()), p384);
        repeat (300) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1 || mm_start_o !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl: got ready=%b start=%b expected 1 / 0", ready_o, mm_start_o); end
        checks++; if (res_o !== '0) begin errors++; $display("FAIL async_reset_res: got %h expected 0", res_o); end
        checks++; if (mm_opa_o !== '0 || mm_opb_o !== '0 || mm_n_o !== '0) begin errors++; $display("FAIL async_reset_ops: got %h / %h / %h expected 0", mm_opa_o, mm_opb_o, mm_n_o); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        b = op_t'(wide_t'(rand_op()) % wide_t'(p384));
        e = exp_t'(rand_op());
        exp_res = ref_modexp(b, e, p384);
        start_run(b, e, p384);
        wait_done(res, st, cy, ok);
        checks++; if (!ok || res !== exp_res) begin errors++; $display("FAIL post_reset_res: got %h expected %h", res, exp_res); end
        checks++; if (st !== exp_mults(e)) begin errors++; $display("FAIL post_reset_mm_count: got %0d expected %0d", st, exp_mults(e)); end
    endtask

    initial begin
        p384 = op_t'((wide_t'(1) << 384) - (wide_t'(1) << 128) - (wide_t'(1) << 96) +
                     (wide_t'(1) << 32) - wide_t'(1));
        reset_n   = 1'b0;
        zeroize   = 1'b0;
        start_i   = 1'b0;
        base_i    = '0;
        exp_i     = '0;
        n_i       = '0;
        n_prime_i = '0;
        r2_i      = '0;
        inject    = 1'b0;
        inj_p     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_exp_zero();
        test_edge_exponents();
        test_random();
        test_busy_start();
        test_zeroize();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
